cnt_ring_gen: RTL

Parametrised successor to the fixed 4-bit ring counter. Provides a WIDTH-bit shift-sequence counter with these features:
- runtime mode select: ring or Johnson (twisted-ring)
- runtime direction select
- synchronous parallel load
- illegal-state self-correction
- terminal-count pulse and a wrap counter

Used as a one-hot/Johnson sequencer for timing-slot and phase generation in the chapter-2 counter family.

---
 rtl/cnt_ring_pkg.sv | 48 ++++
 rtl/cnt_ring_legal_chk.sv | 21 ++
 rtl/cnt_ring_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/cnt_ring_pkg.sv
// Shared types and the shift-step function for the ring/Johnson counter family.
// next_state works on a MAX_W-bit container; callers pass their real width in w.
package cnt_ring_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Bits at or above w are returned as zero.
  function automatic logic [MAX_W-1:0] next_state(
    input logic [MAX_W-1:0] s,
    input mode_e            mode,
    input dir_e             dir,
    input int               w
  );
    logic [MAX_W-1:0] r;
    logic             fb;
    r  = '0;
    fb = 1'b0;
    if (dir == DIR_LEFT) begin
      for (int i = 0; i < MAX_W; i++) begin
        if (i == w - 1) fb = s[i];
      end
      for (int i = 1; i < MAX_W; i++) begin
        if (i < w) r[i] = s[i-1];
      end
      r[0] = (mode == MODE_JOHNSON) ? ~fb : fb;
    end else begin
      fb = s[0];
      for (int i = 0; i < MAX_W - 1; i++) begin
        if (i < w - 1) r[i] = s[i+1];
      end
      for (int i = 0; i < MAX_W; i++) begin
        if (i == w - 1) r[i] = (mode == MODE_JOHNSON) ? ~fb : fb;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_ring_legal_chk.sv
// Combinational legality test of a counter state for the selected mode.
// Johnson states may have at most one linear (non-wrapping) bit transition.
module cnt_ring_legal_chk
  import cnt_ring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] s,
  input  mode_e            mode,
  output logic             legal
);

  logic [WIDTH-2:0] edges;

  assign edges = s[WIDTH-1:1] ^ s[WIDTH-2:0];

  always_comb begin
    legal = (mode == MODE_JOHNSON) ? $onehot0(edges) : $onehot(s);
  end

endmodule

// File: rtl/cnt_ring_gen.sv
// WIDTH-bit ring/Johnson sequencer with load, illegal-state recovery to HOME,
// terminal-count pulse on landing at HOME and a modulo wrap counter.
module cnt_ring_gen
  import cnt_ring_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              err,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH-1:0] HOME = WIDTH'(1);

  logic [WIDTH-1:0]  q_q, q_d;
  logic              tc_q, tc_d;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic              q_legal;
  logic              load_legal;
  logic [WIDTH-1:0]  q_adv;

  cnt_ring_legal_chk #(.WIDTH(WIDTH)) u_chk_q (
    .s     (q_q),
    .mode  (mode_e'(mode)),
    .legal (q_legal)
  );

  cnt_ring_legal_chk #(.WIDTH(WIDTH)) u_chk_load (
    .s     (load_val),
    .mode  (mode_e'(mode)),
    .legal (load_legal)
  );

  assign q_adv = WIDTH'(next_state(MAX_W'(q_q), mode_e'(mode), dir_e'(dir), WIDTH));

  always_comb begin
    q_d     = q_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    wraps_d = wraps_q;
    if (load) begin
      if (load_legal) begin
        q_d = load_val;
      end else begin
        q_d   = HOME;
        err_d = 1'b1;
      end
    end else if (en) begin
      // A state left over from the other mode is replaced rather than advanced.
      if (!q_legal) begin
        q_d   = HOME;
        err_d = 1'b1;
      end else begin
        q_d = q_adv;
        if (q_adv == HOME) begin
          tc_d    = 1'b1;
          wraps_d = wraps_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      q_q     <= HOME;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      wraps_q <= '0;
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      wraps_q <= wraps_d;
    end
  end

  assign q     = q_q;
  assign tc    = tc_q;
  assign err   = err_q;
  assign wraps = wraps_q;

endmodule
